main_ctrl_fsm: RTL and testbench

Multicycle main control state machine for the RV32I integer core. It consumes the opcode latched in the instruction register and the ALU zero flag. It sequences each instruction through fetch, decode, execute, memory and writeback. It produces every datapath enable and mux select, including the instruction-register write strobe that captures PC and instruction. It also handshakes with the unified instruction/data memory through a ready signal.

---
 rtl/main_ctrl_fsm.sv | 247 ++++++++++++++++++++++++
 tb/tb_main_ctrl_fsm.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : main_ctrl_fsm
// Purpose  : Multicycle main control FSM for the RV32I integer core.
//            Sequences each instruction through fetch, decode, execute,
//            memory and writeback. Drives every datapath enable and mux
//            select, and handshakes with the unified memory via MemReady.
// Optional : `define ILLEGAL_TRAP_EN to make unknown opcodes lock the FSM
//            in TRAP (Illegal=1) until reset. When undefined, unknown
//            opcodes are retired silently as a NOP and Illegal is tied 0.
// Ports    : CLK, RST (async, active-high)
//            op[6:0]        opcode from the instruction register
//            Zero           ALU zero flag
//            MemReady       memory access complete
//            IRWrite, PCUpdate, PCWrite, Branch, RegWrite, MemWrite
//            AdrSrc, ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ALUOp[1:0]
//            Retire         final-cycle pulse of each completed instruction
//            State[3:0]     current state (debug)
//            Illegal        illegal-opcode trap flag
// Revision : 1.0 - initial release
// ============================================================================
module main_ctrl_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       PCWrite,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       Retire,
  output logic [3:0] State,
  output logic       Illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  state_t     state_q, state_d;

  // Registered Moore outputs. fetch_q/memwr_q/pcupd_q/retire_q are the
  // state-qualifiers for the MemReady-gated strobes combined below.
  logic       fetch_q;
  logic       pcupd_q;
  logic       memwr_q;
  logic       retire_q;
  logic       branch_q;
  logic       regwrite_q;
  logic       adrsrc_q;
  logic [1:0] resultsrc_q;
  logic [1:0] alusrca_q;
  logic [1:0] alusrcb_q;
  logic [1:0] aluop_q;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_q;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      // fetch_q is clear in the first cycle after reset, so the first
      // fetch can only start after the first rising edge.
      S_FETCH:    if (fetch_q && MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  // --------------------------------------------------------------------------
  // State register and registered outputs (decoded from the next state so
  // they line up with the state they describe).
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_FETCH;
      fetch_q     <= 1'b0;
      pcupd_q     <= 1'b0;
      memwr_q     <= 1'b0;
      retire_q    <= 1'b0;
      branch_q    <= 1'b0;
      regwrite_q  <= 1'b0;
      adrsrc_q    <= 1'b0;
      resultsrc_q <= 2'b10;
      alusrca_q   <= 2'b00;
      alusrcb_q   <= 2'b10;
      aluop_q     <= 2'b00;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fetch_q     <= 1'b0;
      pcupd_q     <= 1'b0;
      memwr_q     <= 1'b0;
      retire_q    <= 1'b0;
      branch_q    <= 1'b0;
      regwrite_q  <= 1'b0;
      adrsrc_q    <= 1'b0;
      resultsrc_q <= 2'b00;
      alusrca_q   <= 2'b00;
      alusrcb_q   <= 2'b00;
      aluop_q     <= 2'b00;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
      case (state_d)
        S_FETCH: begin
          fetch_q     <= 1'b1;
          alusrcb_q   <= 2'b10;
          resultsrc_q <= 2'b10;
        end
        S_DECODE: begin
          alusrca_q <= 2'b01;
          alusrcb_q <= 2'b01;
        end
        S_MEMADR: begin
          alusrca_q <= 2'b10;
          alusrcb_q <= 2'b01;
        end
        S_MEMREAD: begin
          adrsrc_q <= 1'b1;
        end
        S_MEMWB: begin
          resultsrc_q <= 2'b01;
          regwrite_q  <= 1'b1;
          retire_q    <= 1'b1;
        end
        S_MEMWRITE: begin
          adrsrc_q <= 1'b1;
          memwr_q  <= 1'b1;
        end
        S_EXECUTER: begin
          alusrca_q <= 2'b10;
          aluop_q   <= 2'b10;
        end
        S_EXECUTEI: begin
          alusrca_q <= 2'b10;
          alusrcb_q <= 2'b01;
          aluop_q   <= 2'b10;
        end
        S_ALUWB: begin
          regwrite_q <= 1'b1;
          retire_q   <= 1'b1;
        end
        S_BEQ: begin
          alusrca_q <= 2'b10;
          aluop_q   <= 2'b01;
          branch_q  <= 1'b1;
          retire_q  <= 1'b1;
        end
        S_JAL: begin
          alusrca_q <= 2'b01;
          alusrcb_q <= 2'b10;
          pcupd_q   <= 1'b1;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: begin
          illegal_q <= 1'b1;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output assembly: MemReady-gated strobes and the PC enable
  // --------------------------------------------------------------------------
  assign IRWrite   = fetch_q & MemReady;
  assign PCUpdate  = pcupd_q | (fetch_q & MemReady);
  assign PCWrite   = PCUpdate | (branch_q & Zero);
  assign Branch    = branch_q;
  assign RegWrite  = regwrite_q;
  // Store strobe stays high for the whole MEMWRITE stall; the instruction
  // retires in the cycle the memory accepts it.
  assign MemWrite  = memwr_q;
  assign Retire    = retire_q | (memwr_q & MemReady);
  assign AdrSrc    = adrsrc_q;
  assign ResultSrc = resultsrc_q;
  assign ALUSrcA   = alusrca_q;
  assign ALUSrcB   = alusrcb_q;
  assign ALUOp     = aluop_q;
  assign State     = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign Illegal   = illegal_q;
`else
  assign Illegal   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_main_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_ctrl_fsm
// Purpose  : Self-checking bench for main_ctrl_fsm. Each instruction class is
//            described by its list of phases; the per-phase output table and
//            the stall rules give the expected outputs every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_ctrl_fsm;

  localparam int P_FETCH = 0,  P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3;
  localparam int P_MEMWB = 4,  P_MEMWRITE = 5, P_EXR = 6, P_EXI = 7;
  localparam int P_ALUWB = 8,  P_BEQ = 9, P_JAL = 10, P_TRAP = 11;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [6:0] op = 7'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       IRWrite, PCUpdate, PCWrite, Branch, RegWrite, MemWrite, AdrSrc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       Retire, Illegal;
  logic [3:0] State;
  logic [16:0] ctrl_obs;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  main_ctrl_fsm dut (
    .CLK(CLK), .RST(RST), .op(op), .Zero(Zero), .MemReady(MemReady),
    .IRWrite(IRWrite), .PCUpdate(PCUpdate), .PCWrite(PCWrite),
    .Branch(Branch), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .Retire(Retire), .State(State),
    .Illegal(Illegal)
  );

  // bit 1 = Retire, bit 11 = MemWrite
  assign ctrl_obs = {IRWrite, PCUpdate, PCWrite, Branch, RegWrite, MemWrite,
                     AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Retire, Illegal};

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs of one phase, straight from the per-state output table.
  function automatic logic [16:0] exp_ctrl(input int ph, input bit mr, input bit z);
    bit irw = 0, pcu = 0, br = 0, rw = 0, mw = 0, adr = 0, ret = 0, ill = 0, pcw;
    logic [1:0] rs = 2'd0, sa = 2'd0, sb = 2'd0, ao = 2'd0;
    case (ph)
      P_FETCH:    begin sb = 2'd2; rs = 2'd2; irw = mr; pcu = mr; end
      P_DECODE:   begin sa = 2'd1; sb = 2'd1; end
      P_MEMADR:   begin sa = 2'd2; sb = 2'd1; end
      P_MEMREAD:  begin adr = 1; end
      P_MEMWB:    begin rs = 2'd1; rw = 1; ret = 1; end
      P_MEMWRITE: begin adr = 1; mw = 1; ret = mr; end
      P_EXR:      begin sa = 2'd2; ao = 2'd2; end
      P_EXI:      begin sa = 2'd2; sb = 2'd1; ao = 2'd2; end
      P_ALUWB:    begin rw = 1; ret = 1; end
      P_BEQ:      begin sa = 2'd2; ao = 2'd1; br = 1; ret = 1; end
      P_JAL:      begin sa = 2'd1; sb = 2'd2; pcu = 1; end
      P_TRAP:     begin ill = 1; end
      default:    begin end
    endcase
    pcw = pcu | (br & z);
    return {irw, pcu, pcw, br, rw, mw, adr, rs, sa, sb, ao, ret, ill};
  endfunction

  function automatic bit is_legal(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_BEQ) || (o == OP_JAL);
  endfunction

  // Check one cycle with the inputs already driven, then advance.
  task automatic cycle(input int ph, input string tag, output logic [16:0] obs);
    @(negedge CLK);
    check_eq({tag, "/state"}, 32'(State), 32'(ph));
    check_eq({tag, "/ctrl"}, 32'(ctrl_obs), 32'(exp_ctrl(ph, MemReady, Zero)));
    obs = ctrl_obs;
    @(posedge CLK);
    #1;
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases between
  // edges and checks the fetch-disabled first cycle.
  task automatic do_reset(input string tag);
    #1;
    RST = 1'b1; MemReady = 1'b1; Zero = 1'b1;
    #1;
    check_eq({tag, "/rst_state"}, 32'(State), 32'(P_FETCH));
    check_eq({tag, "/rst_ctrl"}, 32'(ctrl_obs), 32'(exp_ctrl(P_FETCH, 1'b0, 1'b1)));
    @(posedge CLK); #2;
    check_eq({tag, "/rst_hold"}, 32'({State, ctrl_obs}),
             32'({4'(P_FETCH), exp_ctrl(P_FETCH, 1'b0, 1'b1)}));
    RST = 1'b0;
    @(negedge CLK);
    check_eq({tag, "/rel_state"}, 32'(State), 32'(P_FETCH));
    check_eq({tag, "/rel_ctrl"}, 32'(ctrl_obs), 32'(exp_ctrl(P_FETCH, 1'b0, 1'b1)));
    @(posedge CLK); #1;
  endtask

  // Runs one instruction. rand_mr randomizes MemReady every cycle; otherwise
  // MemReady is 1 except for stall_mw forced stalls in MEMWRITE. zsel<0 means
  // random Zero.
  task automatic run_instr(input logic [6:0] opc, input bit rand_mr,
                           input int stall_mw, input int zsel, input string tag,
                           output int retires, output int mw_cycles);
    logic [63:0] seq;
    int len, idx, guard, stalls_left, ph;
    logic [16:0] obs;
    case (opc)
      OP_LW:  begin seq = 64'({4'd4, 4'd3, 4'd2, 4'd1, 4'd0}); len = 5; end
      OP_SW:  begin seq = 64'({4'd5, 4'd2, 4'd1, 4'd0}); len = 4; end
      OP_R:   begin seq = 64'({4'd8, 4'd6, 4'd1, 4'd0}); len = 4; end
      OP_I:   begin seq = 64'({4'd8, 4'd7, 4'd1, 4'd0}); len = 4; end
      OP_BEQ: begin seq = 64'({4'd9, 4'd1, 4'd0}); len = 3; end
      OP_JAL: begin seq = 64'({4'd8, 4'd10, 4'd1, 4'd0}); len = 4; end
`ifdef ILLEGAL_TRAP_EN
      default: begin seq = 64'({{10{4'd11}}, 4'd1, 4'd0}); len = 12; end
`else
      default: begin seq = 64'({4'd1, 4'd0}); len = 2; end
`endif
    endcase
    idx = 0; guard = 0; stalls_left = stall_mw; retires = 0; mw_cycles = 0;
    while (idx < len && guard < 200) begin
      ph = int'(seq[idx*4 +: 4]);
      if (rand_mr) MemReady = ($urandom_range(3) != 0);
      else if (ph == P_MEMWRITE && stalls_left > 0) begin
        MemReady = 1'b0;
        stalls_left--;
      end else MemReady = 1'b1;
      Zero = (zsel < 0) ? 1'($urandom_range(1)) : 1'(zsel);
      op   = (ph == P_FETCH) ? 7'($urandom) : opc;
      cycle(ph, tag, obs);
      retires   += int'(obs[1]);
      mw_cycles += int'(obs[11]);
      if (!((ph == P_FETCH || ph == P_MEMREAD || ph == P_MEMWRITE) && !MemReady))
        idx++;
      guard++;
    end
    check_eq({tag, "/completed"}, 32'(idx), 32'(len));
  endtask

  initial begin
    int r, mw, k;
    logic [16:0] obs;
    logic [6:0] opc;

    do_reset("init");

    run_instr(OP_LW, 1'b0, 0, 0, "lw", r, mw);
    check_eq("lw/retires", 32'(r), 32'd1);

    run_instr(OP_SW, 1'b0, 3, 0, "sw_stall", r, mw);
    check_eq("sw_stall/retires", 32'(r), 32'd1);
    check_eq("sw_stall/memwrite_cycles", 32'(mw), 32'd4);

    run_instr(OP_BEQ, 1'b0, 0, 1, "beq_taken", r, mw);
    check_eq("beq_taken/retires", 32'(r), 32'd1);
    run_instr(OP_BEQ, 1'b0, 0, 0, "beq_not", r, mw);
    check_eq("beq_not/retires", 32'(r), 32'd1);

    run_instr(OP_JAL, 1'b0, 0, 0, "jal", r, mw);
    check_eq("jal/retires", 32'(r), 32'd1);
    run_instr(OP_R, 1'b0, 0, 0, "rtype", r, mw);
    check_eq("rtype/retires", 32'(r), 32'd1);
    run_instr(OP_I, 1'b0, 0, 0, "itype", r, mw);
    check_eq("itype/retires", 32'(r), 32'd1);

    // Reset in the middle of a stalled load read.
    op = OP_LW; MemReady = 1'b1; Zero = 1'b0;
    cycle(P_FETCH, "mid_rst", obs);
    cycle(P_DECODE, "mid_rst", obs);
    cycle(P_MEMADR, "mid_rst", obs);
    MemReady = 1'b0;
    cycle(P_MEMREAD, "mid_rst", obs);
    cycle(P_MEMREAD, "mid_rst", obs);
    do_reset("mid_rst");
    run_instr(OP_LW, 1'b0, 0, 0, "post_rst_lw", r, mw);
    check_eq("post_rst_lw/retires", 32'(r), 32'd1);

    // Randomized instruction mix, random MemReady/Zero.
    for (int n = 0; n < 200; n++) begin
      k = int'($urandom_range(7));
      case (k)
        0: opc = OP_LW;
        1: opc = OP_SW;
        2: opc = OP_R;
        3: opc = OP_I;
        4: opc = OP_BEQ;
        5: opc = OP_JAL;
        default: begin
          opc = 7'($urandom);
          while (is_legal(opc)) opc = 7'($urandom);
        end
      endcase
      run_instr(opc, 1'b1, 0, -1, "rand", r, mw);
      check_eq("rand/retires", 32'(r), is_legal(opc) ? 32'd1 : 32'd0);
`ifdef ILLEGAL_TRAP_EN
      if (!is_legal(opc)) do_reset("rand_trap");
`endif
    end

    // Directed illegal opcode.
    run_instr(OP_BAD, 1'b0, 0, 0, "illegal", r, mw);
    check_eq("illegal/retires", 32'(r), 32'd0);
`ifdef ILLEGAL_TRAP_EN
    do_reset("illegal");
`endif
    run_instr(OP_SW, 1'b0, 0, 0, "final_sw", r, mw);
    check_eq("final_sw/retires", 32'(r), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
